edge_detect_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-bit rising-edge pulse generator used for button and control inputs.
- Per channel: synchronise an asynchronous input, debounce it, then emit a registered one-clock pulse on the selected edge type (rise, fall, both, or none).
- Sits between raw board inputs (buttons, switches, external strobes) and control FSMs, which consume the pulses as single-cycle commands.

---
 rtl/edge_detect_multi.sv | 57 +++++
 tb/tb_edge_detect_multi.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchronise, debounce and one-cycle edge pulse generation
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int CNT_W       = $clog2(DEB_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sig,
  input  logic [1:0]    mode,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] level,
  output logic          any_pulse
);
  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CNT_W-1:0] cnt_d  [CH];
  logic [CH-1:0]    s, ev, level_d, pulse_d;
  assign s = sync_q[SYNC_STAGES-1];
  // plain flop chain per channel, nothing between stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // accept a new level after DEB_CYCLES mismatching cycles and qualify the edge by mode
  always_comb begin
    ev      = '0;
    level_d = level;
    pulse_d = '0;
    for (int c = 0; c < CH; c++) begin
      cnt_d[c]   = '0;
      ev[c]      = (s[c] != level[c]) && (cnt_q[c] == CNT_W'(DEB_CYCLES - 1));
      cnt_d[c]   = (s[c] == level[c] || ev[c]) ? '0 : cnt_q[c] + 1'b1;
      level_d[c] = ev[c] ? s[c] : level[c];
      pulse_d[c] = ev[c] && (mode == 2'b00 ? s[c] : mode == 2'b01 ? !s[c] : mode == 2'b10);
    end
  end
  // debounce state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
      level     <= '0;
      pulse     <= '0;
      any_pulse <= 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) cnt_q[c] <= cnt_d[c];
      level     <= level_d;
      pulse     <= pulse_d;
      any_pulse <= |pulse_d;
    end
  end
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed checks of debounce latency, glitch rejection, modes and reset
module tb_edge_detect_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [1:0] mode;
  logic [3:0] pa, la, pb, lb;
  logic       aa, ab;
  int passed = 0;
  int total  = 0;
  int np, nl, prev_t, bad_gap;

  edge_detect_multi dut_a (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode),
    .pulse(pa), .level(la), .any_pulse(aa)
  );

  edge_detect_multi #(.DEB_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode),
    .pulse(pb), .level(lb), .any_pulse(ab)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic window(input int ch, input int hi, input int win, output int n_p, output int n_l);
    logic prev;
    n_p = 0;
    n_l = 0;
    sig[ch] = 1'b1;
    for (int i = 0; i < win; i++) begin
      if (i == hi) sig[ch] = 1'b0;
      prev = la[ch];
      step();
      if (pa[ch]) n_p++;
      if (la[ch] != prev) n_l++;
    end
  endtask

  initial begin
    rst = 1'b1;
    sig = '0;
    mode = 2'b00;
    steps(2);
    rst = 1'b0;
    chk("rst_level", {28'd0, la}, 0);
    chk("rst_pulse", {27'd0, aa, pa}, 0);
    chk("rst_b", {23'd0, ab, pb, lb}, 0);
    steps(2);
    sig = 4'b0001;
    steps(17);
    chk("t1_early", {27'd0, aa, pa}, 0);
    step();
    chk("t1_pulse", {27'd0, aa, pa}, 5'b10001);
    chk("t1_level", {28'd0, la}, 4'b0001);
    step();
    chk("t1_clear", {27'd0, aa, pa}, 0);
    chk("t1_hold", {28'd0, la}, 4'b0001);
    window(1, 15, 40, np, nl);
    chk("t2_glitch_pulses", np, 0);
    chk("t2_glitch_level", nl, 0);
    window(1, 16, 60, np, nl);
    chk("t2_16_pulses", np, 1);
    chk("t2_16_toggles", nl, 2);
    mode = 2'b01;
    window(3, 20, 60, np, nl);
    chk("t3_fall_pulses", np, 1);
    mode = 2'b10;
    window(3, 20, 60, np, nl);
    chk("t3_both_pulses", np, 2);
    mode = 2'b11;
    window(3, 20, 60, np, nl);
    chk("t3_off_pulses", np, 0);
    chk("t3_off_toggles", nl, 2);
    mode = 2'b00;
    sig = '0;
    steps(25);
    chk("t4_idle_level", {28'd0, la}, 0);
    sig = 4'b1011;
    steps(17);
    chk("t4_early", {27'd0, aa, pa}, 0);
    step();
    chk("t4_pulse", {27'd0, aa, pa}, 5'b11011);
    step();
    chk("t4_clear", {27'd0, aa, pa}, 0);
    chk("t4_level", {28'd0, la}, 4'b1011);
    sig = '0;
    steps(25);
    sig = 4'b0100;
    steps(10);
    rst = 1'b1;
    step();
    chk("t5_rst_state", {27'd0, aa, pa}, 0);
    chk("t5_rst_level", {28'd0, la}, 0);
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      if (pa != 0) np++;
    end
    chk("t5_no_early", np, 0);
    step();
    chk("t5_pulse", {27'd0, aa, pa}, 5'b10100);
    step();
    chk("t5_clear", {28'd0, pa}, 0);
    sig = '0;
    steps(5);
    sig = 4'b0001;
    steps(2);
    chk("t6_early", {28'd0, pb}, 0);
    step();
    chk("t6_pulse", {27'd0, ab, pb}, 5'b10001);
    step();
    chk("t6_clear", {28'd0, pb}, 0);
    mode = 2'b10;
    np = 0;
    prev_t = -1;
    bad_gap = 0;
    for (int i = 0; i < 36; i++) begin
      if (i < 32) sig[0] = ((i / 4) % 2) == 1;
      step();
      if (pb[0]) begin
        np++;
        if (prev_t >= 0 && i - prev_t != 4) bad_gap++;
        prev_t = i;
      end
    end
    chk("t6_sq_pulses", np, 8);
    chk("t6_sq_gaps", bad_gap, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
